mips32_mem_arbiter: RTL

//  Shares the single-ported 1024x32 unified instruction/data memory between the fetch stage (IF) and
//  the memory-access stage (D). One access per cycle; read data returns after MEM_LAT cycles with an

---
 rtl/mips32_pkg.sv | 39 +++
 rtl/mips32_rtag_pipe.sv | 42 ++++
 rtl/mips32_mem_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// ============================================================================
// Package     : mips32_pkg
// Description : Shared types and constants for the MIPS32 unified-memory
//               arbiter: read-owner tags, priority states, memory geometry
//               and the flush helper used by the return-tag pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips32_pkg;

  // Unified instruction/data memory depth in 32-bit words
  localparam int MIPS32_MEM_WORDS = 1024;

  // Width of the fetch starvation counter (saturates at all-ones)
  localparam int STARVE_CNT_W = 4;

  // Who is waiting for a read return; OWN_NONE marks stores, idle slots
  // and flushed fetches
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Which requester wins when both ask in the same cycle
  typedef enum logic [0:0] {
    P_DATA  = 1'b0,
    P_FETCH = 1'b1
  } prio_t;

  // A branch flush turns any fetch tag into an empty slot; data tags pass
  function automatic owner_t f_scrub(input owner_t i_tag, input logic i_flush);
    return (i_flush && (i_tag == OWN_IF)) ? OWN_NONE : i_tag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips32_rtag_pipe.sv
// ============================================================================
// Module      : mips32_rtag_pipe
// Description : DEPTH-stage shift register of read-owner tags that tracks
//               each memory read until its data emerges. A flush scrubs
//               every fetch tag in flight, including the one entering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips32_rtag_pipe
  import mips32_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk1,
  input  logic   rst_n,
  input  owner_t i_tag,
  input  logic   i_flush,
  output owner_t o_tag
);

  owner_t r_stage [DEPTH];

  // Advance tags one stage per cycle, scrubbing fetch tags on flush
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= OWN_NONE;
      end
    end else begin
      r_stage[0] <= f_scrub(i_tag, i_flush);
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= f_scrub(r_stage[i-1], i_flush);
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mips32_mem_arbiter.sv
// ============================================================================
// Module      : mips32_mem_arbiter
// Description : Shares one single-ported unified memory between instruction
//               fetch (IF) and data access (D). One access per cycle, grants
//               are combinational, read data returns MEM_LAT cycles later
//               with an owner tag. A starvation counter forces fetch
//               priority after STARVE_MAX consecutive fetch denials.
//               Optional macro MIPS32_ARB_STATS_EN adds saturating 16-bit
//               grant/conflict counters on extra output ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = $clog2(MIPS32_MEM_WORDS),
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  // Fetch port
  input  logic              i_ifetch_req,
  input  logic [ADDR_W-1:0] i_ifetch_addr,
  input  logic              i_ifetch_flush,
  output logic              o_ifetch_gnt,
  output logic              o_ifetch_rvalid,
  output logic [DATA_W-1:0] o_ifetch_rdata,
  // Data port
  input  logic              i_dmem_req,
  input  logic              i_dmem_we,
  input  logic [ADDR_W-1:0] i_dmem_addr,
  input  logic [DATA_W-1:0] i_dmem_wdata,
  output logic              o_dmem_gnt,
  output logic              o_dmem_rvalid,
  output logic [DATA_W-1:0] o_dmem_rdata,
  // Memory macro
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
`ifdef MIPS32_ARB_STATS_EN
  output logic [15:0]       o_stat_if_gnt,
  output logic [15:0]       o_stat_d_gnt,
  output logic [15:0]       o_stat_conflict,
`endif
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] c_STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  prio_t                   r_prio;
  prio_t                   w_prio_nxt;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic [STARVE_CNT_W-1:0] w_starve_nxt;
  logic                    w_if_gnt;
  logic                    w_d_gnt;
  owner_t                  w_tag_in;
  owner_t                  w_tag_out;
  logic [DATA_W-1:0]       r_if_rdata;
  logic [DATA_W-1:0]       r_d_rdata;

  // Grants: a lone requester always wins; on conflict the priority state
  // decides. Gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    w_if_gnt = rst_n && i_ifetch_req && (!i_dmem_req || (r_prio == P_FETCH));
    w_d_gnt  = rst_n && i_dmem_req && !w_if_gnt;
  end

  // Memory command mux: granted port's fields, all-zero when idle
  always_comb begin
    o_mem_en    = w_if_gnt || w_d_gnt;
    o_mem_we    = w_d_gnt && i_dmem_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_if_gnt) begin
      o_mem_addr = i_ifetch_addr;
    end else if (w_d_gnt) begin
      o_mem_addr  = i_dmem_addr;
      o_mem_wdata = i_dmem_wdata;
    end
  end

  assign o_ifetch_gnt = w_if_gnt;
  assign o_dmem_gnt   = w_d_gnt;

  // Starvation count and priority next-state; the switch to P_FETCH takes
  // effect the same edge the count reaches the limit, so the very next
  // conflict goes to fetch
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    w_prio_nxt   = r_prio;
    if (!i_ifetch_req || w_if_gnt) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != '1) begin
      w_starve_nxt = r_starve_cnt + 1'b1;
    end
    case (r_prio)
      P_DATA:  if (w_starve_nxt >= c_STARVE_LIM) w_prio_nxt = P_FETCH;
      P_FETCH: if (w_if_gnt)                     w_prio_nxt = P_DATA;
      default: w_prio_nxt = P_DATA;
    endcase
  end

  // Priority state and starvation counter registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_prio       <= P_DATA;
      r_starve_cnt <= '0;
    end else begin
      r_prio       <= w_prio_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Tag entering the return pipe: reads carry their owner, stores nothing
  always_comb begin
    w_tag_in = OWN_NONE;
    if (w_if_gnt) begin
      w_tag_in = OWN_IF;
    end else if (w_d_gnt && !i_dmem_we) begin
      w_tag_in = OWN_D;
    end
  end

  mips32_rtag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_rtag_pipe (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .i_tag   (w_tag_in),
    .i_flush (i_ifetch_flush),
    .o_tag   (w_tag_out)
  );

  assign o_ifetch_rvalid = (w_tag_out == OWN_IF);
  assign o_dmem_rvalid   = (w_tag_out == OWN_D);

  // Capture returned data so each rdata output holds its last value
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (o_ifetch_rvalid) r_if_rdata <= i_mem_rdata;
      if (o_dmem_rvalid)   r_d_rdata  <= i_mem_rdata;
    end
  end

  assign o_ifetch_rdata = o_ifetch_rvalid ? i_mem_rdata : r_if_rdata;
  assign o_dmem_rdata   = o_dmem_rvalid   ? i_mem_rdata : r_d_rdata;

`ifdef MIPS32_ARB_STATS_EN
  logic [15:0] r_stat_if;
  logic [15:0] r_stat_d;
  logic [15:0] r_stat_cf;

  // Saturating grant and conflict counters
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_if <= '0;
      r_stat_d  <= '0;
      r_stat_cf <= '0;
    end else begin
      if (w_if_gnt && (r_stat_if != '1))                  r_stat_if <= r_stat_if + 1'b1;
      if (w_d_gnt && (r_stat_d != '1))                    r_stat_d  <= r_stat_d + 1'b1;
      if (i_ifetch_req && i_dmem_req && (r_stat_cf != '1)) r_stat_cf <= r_stat_cf + 1'b1;
    end
  end

  assign o_stat_if_gnt   = r_stat_if;
  assign o_stat_d_gnt    = r_stat_d;
  assign o_stat_conflict = r_stat_cf;
`endif

endmodule

`default_nettype wire
